// File: rtl/onehot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_pkg
//  Description : Shared widths and enumerations for the one-hot encoder path.
//  Revision    : 1.0 - initial release
// ============================================================================
package onehot_pkg;

    localparam int ONEHOT_W = 8;
    localparam int CODE_W   = 3;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_ZERO  = 2'd1,
        ERR_MULTI = 2'd2
    } err_class_t;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        STABLE = 1'b1
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/onehot_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_sync_debounce
//  Description : Two-flop synchroniser plus debounce FSM; pulses o_accept once
//                for every newly stable word that differs from the last one.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_sync_debounce
    import onehot_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ONEHOT_W-1:0] i_oh,
    output logic                o_accept,
    output logic [ONEHOT_W-1:0] o_word
);

    localparam logic [7:0] c_cnt_last = 8'(STABLE_CYCLES - 1);

    logic [ONEHOT_W-1:0] r_sync1;
    logic [ONEHOT_W-1:0] r_sync2;
    logic [ONEHOT_W-1:0] r_prev;
    logic [ONEHOT_W-1:0] r_last;
    logic [7:0]          r_cnt;
    logic                r_accept;
    db_state_t           r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_last   <= '0;
            r_cnt    <= '0;
            r_accept <= 1'b0;
            r_state  <= SETTLE;
        end else begin
            r_sync1  <= i_oh;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_accept <= 1'b0;
            case (r_state)
                SETTLE: begin
                    if (r_sync2 != r_prev) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_last) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                        // A re-settled copy of the previous word is not news.
                        if (r_sync2 != r_last) begin
                            r_accept <= 1'b1;
                            r_last   <= r_sync2;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                STABLE: begin
                    if (r_sync2 != r_prev) begin
                        r_state <= SETTLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= SETTLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_accept = r_accept;
    assign o_word   = r_last;

endmodule
`default_nettype wire

// File: rtl/onehot_encoder_rx.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_encoder_rx
//  Description : Debounced 8-bit one-hot to 3-bit index encoder with a
//                valid/ready output register, overrun flag and error counter.
//                Build option ONEHOT_ENC_PRIORITY_EN: multi-hot words resolve
//                to the highest set bit instead of being flagged as errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_encoder_rx
    import onehot_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       oh_in,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [2:0]       out_code,
    output logic [1:0]       out_err,
    output logic             overrun,
    output logic [CNT_W-1:0] err_cnt
);

    logic                w_accept;
    logic [ONEHOT_W-1:0] w_word;
    logic [3:0]          w_pop;
    logic [CODE_W-1:0]   w_hi;
    logic [CODE_W-1:0]   w_code;
    err_class_t          w_err;
    logic                w_load;
    logic                w_drop;

    logic                r_valid;
    logic [CODE_W-1:0]   r_code;
    logic [1:0]          r_err;
    logic                r_overrun;
    logic [CNT_W-1:0]    r_err_cnt;

    onehot_sync_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_oh     (oh_in),
        .o_accept (w_accept),
        .o_word   (w_word)
    );

    // Ascending scan leaves w_hi at the highest set bit.
    always_comb begin
        w_pop = '0;
        w_hi  = '0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (w_word[i]) begin
                w_pop = w_pop + 4'd1;
                w_hi  = CODE_W'(i);
            end
        end
    end

    always_comb begin
        w_code = '0;
        w_err  = ERR_OK;
        if (w_pop == 4'd0) begin
            w_err = ERR_ZERO;
        end else if (w_pop == 4'd1) begin
            w_code = w_hi;
        end else begin
`ifdef ONEHOT_ENC_PRIORITY_EN
            w_code = w_hi;
`else
            w_err  = ERR_MULTI;
`endif
        end
    end

    assign w_load = w_accept && (!r_valid || out_ready);
    assign w_drop = w_accept && r_valid && !out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_err   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_code  <= w_code;
            r_err   <= w_err;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Errors are counted on acceptance, whether the word was loaded or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else if (clr) begin
            r_overrun <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_accept && (w_err != ERR_OK) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_valid;
    assign out_code  = r_code;
    assign out_err   = r_err;
    assign overrun   = r_overrun;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_encoder_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_onehot_encoder_rx
//  Description : Scoreboard bench for onehot_encoder_rx (STABLE_CYCLES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_onehot_encoder_rx;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 8;

    logic             clk;
    logic             rst_n;
    logic [7:0]       oh_in;
    logic             clr;
    logic             out_ready;
    logic             out_valid;
    logic [2:0]       out_code;
    logic [1:0]       out_err;
    logic             overrun;
    logic [CNT_W-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    logic [4:0] sb_q[$];

    onehot_encoder_rx #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .oh_in     (oh_in),
        .clr       (clr),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_err   (out_err),
        .overrun   (overrun),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Consumer side of the scoreboard: every handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                logic [4:0] e;
                e = sb_q.pop_front();
                check("out_code", int'(out_code), int'(e[4:2]));
                check("out_err",  int'(out_err),  int'(e[1:0]));
            end
        end
    end

    task automatic drive(input logic [7:0] w, input logic [2:0] code, input logic [1:0] err,
                         input bit expect_out);
        @(posedge clk);
        #1;
        oh_in = w;
        if (expect_out) sb_q.push_back({code, err});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check(tag, sb_q.size(), 0);
            sb_q.delete();
        end
        idle(2);
    endtask

    task automatic measure(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        oh_in     = 8'h00;
        clr       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",   int'(out_valid), 0);
        check("rst_code",    int'(out_code),  0);
        check("rst_err",     int'(out_err),   0);
        check("rst_overrun", int'(overrun),   0);
        check("rst_errcnt",  int'(err_cnt),   0);
        rst_n = 1'b1;
        idle(12);

        // Single clean word: latency and one-cycle pulse.
        drive(8'h10, 3'd4, 2'd0, 1'b1);
        measure(lat);
        check("latency", lat - 1, STABLE_CYCLES + 3);
        @(negedge clk);
        check("pulse_len", int'(out_valid), 0);
        drain("drain_10");

        // Bouncing input must not produce anything until it settles.
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 8'h01 : 8'h02, 3'd0, 2'd0, 1'b0);
            idle(1);
        end
        drive(8'h02, 3'd1, 2'd0, 1'b1);
        drain("drain_02");

        drive(8'h80, 3'd7, 2'd0, 1'b1);
        drain("drain_80");
        drive(8'h00, 3'd0, 2'd1, 1'b1);
        drain("drain_00");
        check("errcnt_zero", int'(err_cnt), 1);

        // Back-pressure: second word is dropped and flags overrun.
        out_ready = 1'b0;
        drive(8'h04, 3'd2, 2'd0, 1'b1);
        idle(12);
        check("bp_valid", int'(out_valid), 1);
        check("bp_code",  int'(out_code),  2);
        drive(8'h08, 3'd0, 2'd0, 1'b0);
        idle(12);
        check("ovr_code", int'(out_code), 2);
        check("ovr_set",  int'(overrun),  1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("clr_ovr",   int'(overrun),   0);
        check("clr_valid", int'(out_valid), 1);
        check("clr_cnt",   int'(err_cnt),   0);
        out_ready = 1'b1;
        drain("drain_04");

`ifdef ONEHOT_ENC_PRIORITY_EN
        drive(8'h06, 3'd2, 2'd0, 1'b1);
        drain("drain_06");
        check("multi_cnt", int'(err_cnt), 0);
`else
        drive(8'h06, 3'd0, 2'd2, 1'b1);
        drain("drain_06");
        check("multi_cnt", int'(err_cnt), 1);
`endif

        // Reset in the middle of debouncing 8'h20.
        drive(8'h20, 3'd0, 2'd0, 1'b0);
        idle(3);
        oh_in = 8'h40;
        idle(1);
        oh_in = 8'h20;
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_cnt",   int'(err_cnt),   0);
        check("mrst_code",  int'(out_code),  0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.push_back({3'd5, 2'd0});
        measure(lat);
        check("mrst_latency", lat - 1, STABLE_CYCLES + 3);
        drain("drain_20");

        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
